store_rmw_unit: RTL and testbench
=================================

// Module: store_rmw_unit
// PURPOSE
//  Write-side partner of the load extraction path in the multi-cycle datapath.
//  Executes SW/SH/SB against a word-only data memory that has no byte enables.
//  SW is a single write. SH/SB are a read-modify-write: read word, merge lane(s), write word.
//  Sits between the control FSM (Start/Done) and the memory port; also flags misaligned or timed-out stores.
// PARAMETERS
//  MAX_WAIT  16  max cycles a READ/WRITE request waits for MemReady before abort (>=1)
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  Start        in   1   store request; sampled only in IDLE
//  StoreType    in   2   00=SW, 01=SH, 10=SB, 11=reserved (error)
//  Addr         in   32  byte address (ALUOut)
//  StoreData    in   32  rt value; SH uses [15:0], SB uses [7:0]
//  MemAddr      out  32  word address {AddrQ[31:2],2'b00}
//  MemRead      out  1   read request (held until MemReady)
//  MemWrite     out  1   write request (held until MemReady)
//  MemWData     out  32  write word
//  MemRData     in   32  read word, valid when MemReady in READ
//  MemReady     in   1   memory accepts/completes current request this cycle
//  Busy         out  1   high in every state except IDLE
//  Done         out  1   one-cycle completion pulse
//  Err          out  1   valid with Done: 1 = misaligned/reserved/timeout, no write performed
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; MemRead=MemWrite=0; Busy=Done=Err=0; MemAddr=MemWData=0; wait counter=0.
//  Reset mid-operation drops MemRead/MemWrite at once; no partial write is retried.
//  All outputs are registered or decoded from state only (Moore); no comb path from inputs to outputs.
//  States: IDLE, READ, WRITE, DONE.
//   IDLE: on Start, capture Addr/StoreData/StoreType into AddrQ/DataQ/TypeQ.
//    Misaligned (SW Addr[1:0]!=0, SH Addr[0]=1) or type 11 -> DONE with Err=1, no memory access.
//    SW -> WRITE with MemWData=DataQ. SH/SB -> READ.
//   READ: MemRead=1. On MemReady, latch merged word into MemWData -> WRITE.
//    SH: lane AddrQ[1]=0 -> [15:0], =1 -> [31:16] replaced by DataQ[15:0]; other half from MemRData.
//    SB: lane AddrQ[1:0] selects byte [8k+7:8k] replaced by DataQ[7:0]; other bytes from MemRData.
//   WRITE: MemWrite=1. On MemReady -> DONE (Err=0).
//   DONE: Done=1 for exactly one cycle, Err per cause -> IDLE. Busy=1 in DONE.
//  Wait counter: cleared on entry to READ/WRITE; increments each cycle without MemReady.
//   When count reaches MAX_WAIT-1 without MemReady -> DONE with Err=1; request drops next cycle.
//   MemReady in the same cycle as the limit wins (normal progress).
//  Start outside IDLE is ignored (no queueing). Start in the DONE cycle is ignored.
//  MemRead and MemWrite are never high together. MemAddr stable for the whole transaction.
//  Latency with MemReady tied high:
//   SW: Start@0, WRITE@1, Done@2.
//   SH/SB: Start@0, READ@1, WRITE@2, Done@3.
//   Error: Start@0, Done+Err@1.
// TESTING
//  1 SW Addr=0x100 Data=0xDEADBEEF, MemReady=1 -> one write {0x100,0xDEADBEEF}, Done@cycle2, Err=0.
//  2 SB Addr=0x203 Data=0xAB, MemRData=0x11223344 -> MemWData=0xAB223344 @0x200, Done@3.
//  3 SH Addr=0x302 Data=0x5566, MemRData=0x11223344, MemReady delayed 3 cycles on read
//    -> MemRead held 4 cycles, MemWData=0x55663344, Done=1 Err=0.
//  4 SH Addr=0x301 and SW Addr=0x102 -> Done+Err next cycle, MemRead/MemWrite never assert.
//  5 SW with MemReady stuck 0, MAX_WAIT=16 -> MemWrite high 16 cycles, then Done+Err, MemWrite=0.
//  6 rst_n low during READ of SB, plus Start pulses while Busy -> outputs zero immediately, IDLE;
//    Start pulses while Busy produce no extra transactions.

Source files
------------

// File: rtl/store_rmw_unit.sv
`default_nettype none
// ============================================================================
// Module   : store_rmw_unit
// Purpose  : Store engine for a word-only data memory without byte enables.
//            SW is issued as a single word write. SH/SB are performed as a
//            read-modify-write: read the word, splice in the new lane(s),
//            write the word back. Misaligned stores, the reserved store type
//            and memory requests that never see MemReady end with Err and
//            no write.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   Start      in   1   store request, sampled only in IDLE
//   StoreType  in   2   00=SW 01=SH 10=SB 11=reserved
//   Addr       in  32   byte address
//   StoreData  in  32   store value (SH uses [15:0], SB uses [7:0])
//   MemAddr    out 32   word-aligned memory address
//   MemRead    out  1   memory read request
//   MemWrite   out  1   memory write request
//   MemWData   out 32   memory write word
//   MemRData   in  32   memory read word, valid with MemReady during READ
//   MemReady   in   1   memory accepts/completes the current request
//   Busy       out  1   high whenever not IDLE
//   Done       out  1   one-cycle completion pulse
//   Err        out  1   qualifies Done: store aborted, nothing written
// ============================================================================
module store_rmw_unit #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Start,
  input  logic [1:0]  StoreType,
  input  logic [31:0] Addr,
  input  logic [31:0] StoreData,
  output logic [31:0] MemAddr,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRData,
  input  logic        MemReady,
  output logic        Busy,
  output logic        Done,
  output logic        Err
);

  // Counter is wide enough to hold MAX_WAIT-1.
  localparam int              CNT_W      = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT - 1);

  localparam logic [1:0] ST_SW = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SB = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [1:0]       type_q;
  logic [1:0]       lane_q;   // Addr[1:0] of the captured store
  logic [15:0]      data_q;   // only the low half is ever merged
  logic [CNT_W-1:0] wait_cnt;

  logic             misaligned;

  // Reserved type is treated like a misaligned store: flagged, never issued.
  always_comb begin
    misaligned = 1'b0;
    case (StoreType)
      ST_SW:   misaligned = (Addr[1:0] != 2'b00);
      ST_SH:   misaligned = Addr[0];
      ST_SB:   misaligned = 1'b0;
      default: misaligned = 1'b1;
    endcase
  end

  // Replace the selected halfword or byte of the read word with store data.
  function automatic logic [31:0] merge_lane(
    input logic [31:0] word,
    input logic [15:0] data,
    input logic        is_half,
    input logic [1:0]  lane
  );
    logic [31:0] merged;
    merged = word;
    if (is_half) begin
      if (lane[1]) merged[31:16] = data;
      else         merged[15:0]  = data;
    end else begin
      case (lane)
        2'd0:    merged[7:0]   = data[7:0];
        2'd1:    merged[15:8]  = data[7:0];
        2'd2:    merged[23:16] = data[7:0];
        default: merged[31:24] = data[7:0];
      endcase
    end
    return merged;
  endfunction

  // Busy is decoded from state alone, so it stays Moore.
  assign Busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      type_q   <= 2'b00;
      lane_q   <= 2'b00;
      data_q   <= 16'h0000;
      wait_cnt <= '0;
      MemAddr  <= 32'h0000_0000;
      MemWData <= 32'h0000_0000;
      MemRead  <= 1'b0;
      MemWrite <= 1'b0;
      Done     <= 1'b0;
      Err      <= 1'b0;
    end else begin
      // Done/Err are single-cycle: only the transition into DONE raises them.
      Done <= 1'b0;
      Err  <= 1'b0;

      case (state)
        S_IDLE: begin
          if (Start) begin
            MemAddr  <= {Addr[31:2], 2'b00};
            lane_q   <= Addr[1:0];
            data_q   <= StoreData[15:0];
            type_q   <= StoreType;
            wait_cnt <= '0;
            if (misaligned) begin
              state <= S_DONE;
              Done  <= 1'b1;
              Err   <= 1'b1;
            end else if (StoreType == ST_SW) begin
              state    <= S_WRITE;
              MemWrite <= 1'b1;
              MemWData <= StoreData;
            end else begin
              state   <= S_READ;
              MemRead <= 1'b1;
            end
          end
        end

        S_READ: begin
          // MemReady on the limit cycle still counts as a completed read.
          if (MemReady) begin
            MemRead  <= 1'b0;
            MemWrite <= 1'b1;
            MemWData <= merge_lane(MemRData, data_q, (type_q == ST_SH), lane_q);
            wait_cnt <= '0;
            state    <= S_WRITE;
          end else if (wait_cnt == WAIT_LIMIT) begin
            MemRead <= 1'b0;
            state   <= S_DONE;
            Done    <= 1'b1;
            Err     <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        S_WRITE: begin
          if (MemReady) begin
            MemWrite <= 1'b0;
            state    <= S_DONE;
            Done     <= 1'b1;
          end else if (wait_cnt == WAIT_LIMIT) begin
            MemWrite <= 1'b0;
            state    <= S_DONE;
            Done     <= 1'b1;
            Err      <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        S_DONE: begin
          // Start is deliberately not looked at here.
          state <= S_IDLE;
        end

        default: begin
          state    <= S_IDLE;
          MemRead  <= 1'b0;
          MemWrite <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_store_rmw_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_store_rmw_unit
// Purpose  : Scoreboard bench for store_rmw_unit with a behavioural memory
//            responder and a reference model of the store semantics.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_rmw_unit;

  localparam int MAX_WAIT = 16;

  logic        clk;
  logic        rst_n;
  logic        Start;
  logic [1:0]  StoreType;
  logic [31:0] Addr;
  logic [31:0] StoreData;
  logic [31:0] MemAddr;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] MemWData;
  logic [31:0] MemRData;
  logic        MemReady;
  logic        Busy;
  logic        Done;
  logic        Err;

  store_rmw_unit #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Start     (Start),
    .StoreType (StoreType),
    .Addr      (Addr),
    .StoreData (StoreData),
    .MemAddr   (MemAddr),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .MemWData  (MemWData),
    .MemRData  (MemRData),
    .MemReady  (MemReady),
    .Busy      (Busy),
    .Done      (Done),
    .Err       (Err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc;
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // --------------------------------------------------------------------------
  // Scoreboard bookkeeping
  // --------------------------------------------------------------------------
  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    bit          err;
    bit          has_write;
    int          lat;
    int          rcyc;
    int          wcyc;
    int          start;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] wr_log[$];
  int          rd_cycles;
  int          wr_cycles;
  int          rd_delay;
  int          wr_delay;
  int          vec;
  int          miss;

  logic [31:0] ref_mem  [int unsigned];
  logic [31:0] phys_mem [int unsigned];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vec++;
    if (act !== req) begin
      miss++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int unsigned widx);
    return (widx * 32'h9E37_79B9) ^ 32'h5A5A_A5A5;
  endfunction

  function automatic logic [31:0] ref_rd(input int unsigned widx);
    return ref_mem.exists(widx) ? ref_mem[widx] : init_word(widx);
  endfunction

  function automatic logic [31:0] phys_rd(input int unsigned widx);
    return phys_mem.exists(widx) ? phys_mem[widx] : init_word(widx);
  endfunction

  // Reference model: decides outcome, latency, request durations and the
  // written word from the store rules and the memory's response delays.
  function automatic void model(input logic [1:0] typ, input logic [31:0] addr,
                                input logic [31:0] data, input int dr, input int dw,
                                output exp_t e);
    int unsigned widx;
    int          shift;
    int          base;
    logic [31:0] mask;
    logic [31:0] old;
    bit          bad;
    bit          rmw;
    widx = addr / 4;
    bad  = (typ == 2'd3) || (typ == 2'd0 && (addr % 4) != 0) || (typ == 2'd1 && (addr % 2) != 0);
    rmw  = (typ != 2'd0);
    e.waddr     = widx * 4;
    e.wdata     = 32'h0;
    e.err       = 1'b0;
    e.has_write = 1'b0;
    e.rcyc      = 0;
    e.wcyc      = 0;
    e.start     = 0;
    e.lat       = 0;
    if (bad) begin
      e.err = 1'b1;
      e.lat = 1;
      return;
    end
    if (rmw) begin
      if (dr >= MAX_WAIT) begin
        e.err  = 1'b1;
        e.rcyc = MAX_WAIT;
        e.lat  = 1 + MAX_WAIT;
        return;
      end
      e.rcyc = dr + 1;
    end
    base = rmw ? 2 + dr : 1;
    if (dw >= MAX_WAIT) begin
      e.err  = 1'b1;
      e.wcyc = MAX_WAIT;
      e.lat  = base + MAX_WAIT;
      return;
    end
    e.wcyc      = dw + 1;
    e.lat       = base + dw + 1;
    e.has_write = 1'b1;
    if (typ == 2'd0) begin
      e.wdata = data;
    end else begin
      old = ref_rd(widx);
      if (typ == 2'd1) begin
        shift = 16 * ((addr % 4) / 2);
        mask  = 32'h0000_FFFF << shift;
      end else begin
        shift = 8 * (addr % 4);
        mask  = 32'h0000_00FF << shift;
      end
      e.wdata = (old & ~mask) | ((data << shift) & mask);
    end
    ref_mem[widx] = e.wdata;
  endfunction

  // --------------------------------------------------------------------------
  // Memory responder: grants a request after a programmed number of cycles.
  // --------------------------------------------------------------------------
  int         age;
  logic [1:0] sig;
  logic [1:0] prev_sig;

  initial begin
    MemReady  = 1'b0;
    MemRData  = 32'h0;
    age       = 0;
    prev_sig  = 2'b00;
    rd_cycles = 0;
    wr_cycles = 0;
    forever begin
      @(negedge clk);
      sig = {MemRead, MemWrite};
      if (sig != prev_sig) age = 0;
      prev_sig = sig;
      MemReady = 1'b0;
      MemRData = $urandom;
      if (MemRead) begin
        rd_cycles++;
        if (age == rd_delay) begin
          MemReady = 1'b1;
          MemRData = phys_rd(int'(MemAddr[31:2]));
        end
      end else if (MemWrite) begin
        wr_cycles++;
        if (age == wr_delay) begin
          MemReady = 1'b1;
          phys_mem[int'(MemAddr[31:2])] = MemWData;
          wr_log.push_back({MemAddr, MemWData});
        end
      end else begin
        MemReady = 1'($urandom_range(0, 1));
      end
      age++;
    end
  end

  // --------------------------------------------------------------------------
  // Monitor: protocol checks every cycle, scoreboard pop on Done.
  // --------------------------------------------------------------------------
  bit   prev_done;
  exp_t mon_e;

  initial begin
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_done = 1'b0;
      end else begin
        chk("req_exclusive", {31'd0, MemRead & MemWrite}, 32'd0);
        if (Err) chk("err_without_done", {31'd0, Done}, 32'd1);
        if (prev_done) chk("done_pulse_width", {31'd0, Done}, 32'd0);
        if (MemRead || MemWrite) begin
          if (exp_q.size() == 0) begin
            chk("spurious_request", {30'd0, MemRead, MemWrite}, 32'd0);
          end else begin
            chk("memaddr", MemAddr, exp_q[0].waddr);
          end
        end
        if (Done) begin
          chk("busy_in_done", {31'd0, Busy}, 32'd1);
          if (exp_q.size() == 0) begin
            chk("unexpected_done", {31'd0, Done}, 32'd0);
          end else begin
            mon_e = exp_q.pop_front();
            chk("err", {31'd0, Err}, {31'd0, mon_e.err});
            chk("latency", cyc - mon_e.start, mon_e.lat);
            chk("memread_cycles", rd_cycles, mon_e.rcyc);
            chk("memwrite_cycles", wr_cycles, mon_e.wcyc);
            chk("write_count", wr_log.size(), mon_e.has_write ? 1 : 0);
            if (mon_e.has_write && wr_log.size() > 0) begin
              chk("write_addr", wr_log[0][63:32], mon_e.waddr);
              chk("write_data", wr_log[0][31:0], mon_e.wdata);
            end
          end
          wr_log.delete();
          rd_cycles = 0;
          wr_cycles = 0;
        end
        prev_done = Done;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic junk_start();
    Start     = ($urandom_range(0, 2) == 0);
    StoreType = 2'($urandom);
    Addr      = $urandom;
    StoreData = $urandom;
  endtask

  task automatic flush_after_reset();
    exp_q.delete();
    wr_log.delete();
    rd_cycles = 0;
    wr_cycles = 0;
    Start     = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (Done) begin
        junk_start();   // lands in the DONE cycle, must be ignored
        break;
      end
      junk_start();     // pulses while busy, must be ignored
      n++;
      if (n > 200) begin
        vec++;
        miss++;
        $display("FAIL done_timeout: got no Done after %0d cycles expected Done", n);
        #2 rst_n = 1'b0;
        #1 flush_after_reset();
        @(negedge clk);
        rst_n = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_txn(input logic [1:0] typ, input logic [31:0] addr,
                         input logic [31:0] data, input int dr, input int dw);
    exp_t e;
    model(typ, addr, data, dr, dw, e);
    @(negedge clk);
    rd_delay  = dr;
    wr_delay  = dw;
    Start     = 1'b1;
    StoreType = typ;
    Addr      = addr;
    StoreData = data;
    e.start   = cyc;
    exp_q.push_back(e);
    wait_done();
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    Start = 1'b0;
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] word);
    ref_mem[addr / 4]  = word;
    phys_mem[addr / 4] = word;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_memread"},  {31'd0, MemRead},  32'd0);
    chk({tag, "_memwrite"}, {31'd0, MemWrite}, 32'd0);
    chk({tag, "_busy"},     {31'd0, Busy},     32'd0);
    chk({tag, "_done"},     {31'd0, Done},     32'd0);
    chk({tag, "_err"},      {31'd0, Err},      32'd0);
    chk({tag, "_memaddr"},  MemAddr,           32'd0);
    chk({tag, "_memwdata"}, MemWData,          32'd0);
  endtask

  // SB stalled in READ, Start pulses while busy, then asynchronous reset.
  task automatic reset_mid_test();
    exp_t e;
    e.waddr = 32'h0000_0400; e.wdata = 32'h0; e.err = 1'b0; e.has_write = 1'b0;
    e.lat = 0; e.rcyc = 0; e.wcyc = 0;
    @(negedge clk);
    rd_delay  = 1000;
    wr_delay  = 0;
    Start     = 1'b1;
    StoreType = 2'b10;
    Addr      = 32'h0000_0403;
    StoreData = $urandom;
    e.start   = cyc;
    exp_q.push_back(e);
    repeat (5) begin
      @(negedge clk);
      junk_start();
    end
    chk("busy_before_reset", {31'd0, Busy}, 32'd1);
    chk("memread_before_reset", {31'd0, MemRead}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    flush_after_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) idle_cycle();
    chk("idle_after_reset", {31'd0, Busy}, 32'd0);
  endtask

  logic [1:0]  r_typ;
  logic [31:0] r_addr;
  int          r_dr;
  int          r_dw;

  function automatic int pick_delay();
    return ($urandom_range(0, 9) < 7) ? $urandom_range(0, 3) : $urandom_range(MAX_WAIT - 2, MAX_WAIT + 1);
  endfunction

  initial begin
    vec       = 0;
    miss      = 0;
    rst_n     = 1'b0;
    Start     = 1'b0;
    StoreType = 2'b00;
    Addr      = 32'h0;
    StoreData = 32'h0;
    rd_delay  = 0;
    wr_delay  = 0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    preload(32'h0000_0200, 32'h1122_3344);
    preload(32'h0000_0300, 32'h1122_3344);

    run_txn(2'b00, 32'h0000_0100, 32'hDEAD_BEEF, 0, 0);  // SW
    run_txn(2'b10, 32'h0000_0203, 32'h0000_00AB, 0, 0);  // SB top byte
    run_txn(2'b01, 32'h0000_0302, 32'h0000_5566, 3, 0);  // SH upper half, slow read
    run_txn(2'b01, 32'h0000_0301, 32'h1234_5678, 0, 0);  // SH misaligned
    run_txn(2'b00, 32'h0000_0102, 32'h1234_5678, 0, 0);  // SW misaligned
    run_txn(2'b11, 32'h0000_0100, 32'h1234_5678, 0, 0);  // reserved type
    run_txn(2'b00, 32'h0000_0104, 32'hCAFE_F00D, 0, 1000);          // write never ready
    run_txn(2'b10, 32'h0000_0201, 32'h0000_00C3, MAX_WAIT - 1, 2);  // ready on limit cycle
    run_txn(2'b01, 32'h0000_0200, 32'h0000_9A9A, MAX_WAIT, 0);      // read timeout
    run_txn(2'b00, 32'h0000_0108, 32'h0BAD_CAFE, 0, MAX_WAIT - 1);
    run_txn(2'b10, 32'h0000_020C, 32'h0000_0077, 1, MAX_WAIT);      // write timeout after read

    reset_mid_test();

    for (int i = 0; i < 150; i++) begin
      r_typ  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      r_addr = 32'h0000_1000 + 32'($urandom_range(0, 63));
      r_dr   = pick_delay();
      r_dw   = pick_delay();
      run_txn(r_typ, r_addr, $urandom, r_dr, r_dw);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    repeat (4) idle_cycle();
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
`default_nettype wire
